// File: rtl/aes_kat_sequencer.sv
// Known-answer self-test sequencer. It walks a vector ROM and drives a shared AES core
// through a start/done handshake. It accumulates the fail count, the first failing index and per-class LEDs.
module aes_kat_sequencer #(
  parameter int NUM_VEC = 6,
  parameter int TIMEOUT = 64,
  parameter int IDX_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass_all,
  output logic [IDX_W-1:0] fail_count,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic             timeout_flag,
  output logic [5:0]       led,
  output logic [IDX_W-1:0] vec_addr,
  input  logic [255:0]     vec_key,
  input  logic [1:0]       vec_ksize,
  input  logic             vec_dir,
  input  logic [127:0]     vec_din,
  input  logic [127:0]     vec_exp,
  output logic             core_start,
  output logic [255:0]     core_key,
  output logic [1:0]       core_ksize,
  output logic             core_dir,
  output logic [127:0]     core_din,
  input  logic             core_done,
  input  logic [127:0]     core_dout
);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_ROM, S_LAUNCH, S_WAIT_CORE, S_CHECK, S_NEXT
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  tmo_cnt_reg;
  logic [127:0]      exp_reg, result_reg;
  logic [5:0]        class_seen_reg, class_fail_reg, class_bit;
  logic              vec_fail, cnt_expired, result_ok, last_vec;

  assign cnt_expired = (tmo_cnt_reg == CNT_LAST);
  assign result_ok   = (result_reg == exp_reg);
  assign last_vec    = (vec_addr == LAST_IDX);
  assign class_bit   = 6'b1 << ({2'b00, core_dir} * 3'd3 + {1'b0, core_ksize});
  // Decoded from the state register so it can never outlive LAUNCH, even across reset.
  assign core_start  = (state_reg == S_LAUNCH);

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    vec_fail   = 1'b0;
    case (state_reg)
      S_IDLE:     if (start) state_next = S_FETCH;
      S_FETCH:    state_next = S_WAIT_ROM;
      S_WAIT_ROM: begin
        if (vec_ksize == 2'd3) begin
          vec_fail   = 1'b1;
          state_next = S_NEXT;
        end else begin
          state_next = S_LAUNCH;
        end
      end
      S_LAUNCH:   state_next = S_WAIT_CORE;
      S_WAIT_CORE: begin
        if (core_done) begin
          state_next = S_CHECK;
        end else if (cnt_expired) begin
          vec_fail   = 1'b1;
          state_next = S_NEXT;
        end
      end
      S_CHECK: begin
        vec_fail   = !result_ok;
        state_next = S_NEXT;
      end
      S_NEXT:     state_next = last_vec ? S_IDLE : S_FETCH;
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      pass_all       <= 1'b0;
      fail_count     <= '0;
      first_fail_idx <= '1;
      timeout_flag   <= 1'b0;
      led            <= '0;
      vec_addr       <= '0;
      core_key       <= '0;
      core_ksize     <= '0;
      core_dir       <= 1'b0;
      core_din       <= '0;
      exp_reg        <= '0;
      result_reg     <= '0;
      tmo_cnt_reg    <= '0;
      class_seen_reg <= '0;
      class_fail_reg <= '0;
    end else begin
      if (vec_fail) begin
        if (fail_count != '1)     fail_count     <= fail_count + IDX_W'(1);
        if (first_fail_idx == '1) first_fail_idx <= vec_addr;
      end
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            fail_count     <= '0;
            first_fail_idx <= '1;
            timeout_flag   <= 1'b0;
            led            <= '0;
            class_seen_reg <= '0;
            class_fail_reg <= '0;
            done           <= 1'b0;
            busy           <= 1'b1;
            vec_addr       <= '0;
          end
        end
        S_WAIT_ROM: begin
          core_key   <= vec_key;
          core_ksize <= vec_ksize;
          core_dir   <= vec_dir;
          core_din   <= vec_din;
          exp_reg    <= vec_exp;
        end
        S_LAUNCH:   tmo_cnt_reg <= '0;
        S_WAIT_CORE: begin
          if (core_done) begin
            result_reg <= core_dout;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
            if (cnt_expired) timeout_flag <= 1'b1;
          end
        end
        S_CHECK: begin
          class_seen_reg <= class_seen_reg | class_bit;
          if (!result_ok) class_fail_reg <= class_fail_reg | class_bit;
          led <= (class_seen_reg | class_bit) & ~(class_fail_reg | (result_ok ? 6'b0 : class_bit));
        end
        S_NEXT: begin
          if (last_vec) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            pass_all <= (fail_count == '0);
          end else begin
            vec_addr <= vec_addr + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/aes_kat_sequencer.md
Name: aes_kat_sequencer

Overview:
Sequential known-answer self-test controller for the AES encrypt/decrypt cores. It walks a parameterised table of test vectors covering 128/192/256-bit keys and both directions. For each vector it drives one AES core through a start/done handshake, compares the result against the expected block, and accumulates pass/fail status. It sits between the board-level enable/LED logic and a shared multi-key-size AES core.

Parameters:
NUM_VEC, 6, number of vectors in the table (1..255)
TIMEOUT, 64, maximum cycles to wait for core_done before the vector is failed (>=2)
IDX_W, 8, width of vec_addr and first_fail_idx

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
start  in  1  pulse; begins a run when idle
busy  out  1  high while a run is in progress
done  out  1  high from end of run until next accepted start
pass_all  out  1  valid when done; 1 when every vector passed
fail_count  out  IDX_W  failed vectors in current/last run
first_fail_idx  out  IDX_W  index of first failing vector; all-ones if none
timeout_flag  out  1  sticky per run; any vector timed out
led  out  6  per-class pass status, bit = dir*3 + ksize
vec_addr  out  IDX_W  vector ROM address
vec_key  in  256  key, left-aligned (128-bit key in [255:128])
vec_ksize  in  2  0=128, 1=192, 2=256, 3=invalid
vec_dir  in  1  0=encrypt, 1=decrypt
vec_din  in  128  input block
vec_exp  in  128  expected output block
core_start  out  1  one-cycle launch pulse
core_key  out  256  registered copy of vec_key
core_ksize  out  2  registered copy of vec_ksize
core_dir  out  1  registered copy of vec_dir
core_din  out  128  registered copy of vec_din
core_done  in  1  one-cycle completion pulse from core
core_dout  in  128  core result, valid with core_done

Behaviour:
- Reset values: busy=0, done=0, pass_all=0, fail_count=0, first_fail_idx=all-ones, timeout_flag=0, led=0, vec_addr=0, core_start=0, core_* data=0. State=IDLE.
- Reset takes priority at any time, including mid-run. Core handshake is abandoned and core_start is never left high.
- ROM read is synchronous. Data for vec_addr is valid one cycle after the address is driven.
- States:
  - IDLE: on start, clear fail_count, timeout_flag, led and the class-seen/class-fail registers. Set first_fail_idx=all-ones, done=0, busy=1, vec_addr=0. Go to FETCH.
  - FETCH: address stable; go to WAIT_ROM.
  - WAIT_ROM: latch vec_* into core_* and a local expected register. If vec_ksize==3, count the vector as a fail without launching the core and go to NEXT. Otherwise go to LAUNCH.
  - LAUNCH: core_start=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_CORE.
  - WAIT_CORE: on core_done, register core_dout and go to CHECK. When the counter reaches TIMEOUT-1 without core_done, set timeout_flag, count a fail and go to NEXT.
  - CHECK: pass if result==expected. Set class_seen[dir*3+ksize]. On fail, also set class_fail for that class. Go to NEXT.
  - NEXT: if vec_addr==NUM_VEC-1, go to IDLE with busy=0, done=1, pass_all=(fail_count==0). Otherwise increment vec_addr and go to FETCH.
- Every fail: fail_count saturates at all-ones. first_fail_idx is written only while it is still all-ones.
- led=class_seen & ~class_fail, updated at CHECK. A class with no vectors reads 0.
- core_done outside WAIT_CORE is ignored. start while busy is ignored. start in the same cycle as done rises is ignored.
- Per-vector latency for a core taking L cycles from start to done: L+5 cycles, counted FETCH through NEXT.

Test Plan:
- Six FIPS-197 vectors (128/192/256 encrypt and decrypt, plaintext 00112233445566778899aabbccddeeff, 128-bit ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a), model core latency 3 -> done=1 after 48 cycles, pass_all=1, fail_count=0, led=6'b111111, first_fail_idx=8'hFF.
- Same table with vector 2 expected value corrupted (flip bit 0) -> fail_count=1, first_fail_idx=2, led=6'b111011, pass_all=0.
- TIMEOUT=8, model never asserts core_done on vector 0 -> timeout_flag=1, first_fail_idx=0, remaining vectors run, fail_count=1.
- Vector 4 with ksize=3 -> core_start never pulses for index 4, fail_count=1, first_fail_idx=4.
- reset asserted in WAIT_CORE of vector 3 -> next cycle all outputs at reset values. A new start runs all vectors from index 0.
- start pulsed while busy, plus spurious core_done in FETCH -> no restart, no extra fail, results identical to the clean run.
